reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 14 +
 rtl/sb_pending.sv | 48 ++++
 rtl/reg_file_sb.sv | 45 ++++
 tb/tb_reg_file_sb.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: address and count width helpers shared by the register file slice
package reg_file_sb_pkg;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    function automatic int aw_of(input int depth);
        return clog2(depth) > 1 ? clog2(depth) : 1;
    endfunction
    function automatic int cw_of(input int depth);
        return clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sb_pending.sv
// sb_pending: reservation scoreboard holding the pending bits, their running count and busy lookup
module sb_pending import reg_file_sb_pkg::*; #(
    parameter int DEPTH = 8,
    parameter bit ZERO_REG = 0,
    parameter bit BYPASS = 1,
    localparam int AW = aw_of(DEPTH),
    localparam int CW = cw_of(DEPTH)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          write,
    input  logic [AW-1:0] waddr,
    input  logic          issue,
    input  logic [AW-1:0] iaddr,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic [CW-1:0] pend_cnt
);
    localparam int N = 1 << AW;
    logic [N-1:0] pending, pend_nxt;
    logic set, clr, inc, dec;
    function automatic logic ok(input logic [AW-1:0] a);
        return int'(a) < DEPTH && !(ZERO_REG && a == '0);
    endfunction
    assign set = issue && ok(iaddr);
    assign clr = write && ok(waddr);
    // a same-address issue re-reserves, so the write does not retire a reservation then
    assign inc = set && !pending[iaddr];
    assign dec = clr && pending[waddr] && !(set && iaddr == waddr);
    always_comb begin
        pend_nxt = pending;
        if (clr) pend_nxt[waddr] = 1'b0;
        if (set) pend_nxt[iaddr] = 1'b1;
    end
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            pend_cnt <= pend_cnt + CW'(inc) - CW'(dec);
        end
    end
    assign busy_a = pending[raddr_a] && !(BYPASS && write && waddr == raddr_a);
    assign busy_b = pending[raddr_b] && !(BYPASS && write && waddr == raddr_b);
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read one-write register file with write bypass and a reservation scoreboard
module reg_file_sb import reg_file_sb_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter logic [WIDTH-1:0] INI = '0,
    parameter bit ZERO_REG = 0,
    parameter bit BYPASS = 1,
    localparam int AW = aw_of(DEPTH),
    localparam int CW = cw_of(DEPTH)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             busy_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             busy_b,
    input  logic             write,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             issue,
    input  logic [AW-1:0]    iaddr,
    output logic [CW-1:0]    pend_cnt
);
    localparam int N = 1 << AW;
    logic [WIDTH-1:0] regs [N];
    function automatic logic ok(input logic [AW-1:0] a);
        return int'(a) < DEPTH && !(ZERO_REG && a == '0);
    endfunction
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) regs[i] <= (ZERO_REG && i == 0) ? '0 : INI;
        end else if (write && ok(waddr)) begin
            regs[waddr] <= wdata;
        end
    end
    // unmapped and hardwired-zero addresses read 0 ahead of any bypass
    assign rdata_a = !ok(raddr_a) ? '0 : (BYPASS && write && waddr == raddr_a) ? wdata : regs[raddr_a];
    assign rdata_b = !ok(raddr_b) ? '0 : (BYPASS && write && waddr == raddr_b) ? wdata : regs[raddr_b];
    sb_pending #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)) u_pending (
        .clock(clock), .resetn(resetn), .write(write), .waddr(waddr), .issue(issue), .iaddr(iaddr),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .busy_a(busy_a), .busy_b(busy_b), .pend_cnt(pend_cnt)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench driving three configurations against a behavioural model
module tb_reg_file_sb;
    localparam logic [15:0] INI = 16'h00A5;
    logic clock = 0, resetn = 0, write = 0, issue = 0;
    logic [2:0] raddr_a = 0, raddr_b = 0, waddr = 0, iaddr = 0;
    logic [15:0] wdata = 0;
    logic [15:0] rda [3], rdb [3];
    logic ba [3], bb [3];
    logic [3:0] cnt0, cnt1;
    logic [2:0] cnt2;
    int vectors = 0, miscompares = 0;
    typedef struct packed {
        logic [2:0][15:0] ra, rb;
        logic [2:0] ba, bb;
        logic [2:0][3:0] cnt;
    } exp_t;
    exp_t q[$];
    logic [15:0] mem [3][8];
    bit pend [3][8];
    always #5 clock = ~clock;
    // k=0: DEPTH 8 bypass; k=1: DEPTH 8 no bypass; k=2: DEPTH 6 bypass with hardwired zero
    reg_file_sb #(.WIDTH(16), .DEPTH(8), .INI(INI), .ZERO_REG(0), .BYPASS(1)) u0 (
        .clock(clock), .resetn(resetn), .raddr_a(raddr_a), .rdata_a(rda[0]), .busy_a(ba[0]),
        .raddr_b(raddr_b), .rdata_b(rdb[0]), .busy_b(bb[0]), .write(write), .waddr(waddr),
        .wdata(wdata), .issue(issue), .iaddr(iaddr), .pend_cnt(cnt0));
    reg_file_sb #(.WIDTH(16), .DEPTH(8), .INI(INI), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clock(clock), .resetn(resetn), .raddr_a(raddr_a), .rdata_a(rda[1]), .busy_a(ba[1]),
        .raddr_b(raddr_b), .rdata_b(rdb[1]), .busy_b(bb[1]), .write(write), .waddr(waddr),
        .wdata(wdata), .issue(issue), .iaddr(iaddr), .pend_cnt(cnt1));
    reg_file_sb #(.WIDTH(16), .DEPTH(6), .INI(INI), .ZERO_REG(1), .BYPASS(1)) u2 (
        .clock(clock), .resetn(resetn), .raddr_a(raddr_a), .rdata_a(rda[2]), .busy_a(ba[2]),
        .raddr_b(raddr_b), .rdata_b(rdb[2]), .busy_b(bb[2]), .write(write), .waddr(waddr),
        .wdata(wdata), .issue(issue), .iaddr(iaddr), .pend_cnt(cnt2));
    function automatic int dep(int k); return k == 2 ? 6 : 8; endfunction
    function automatic bit byp(int k); return k != 1; endfunction
    function automatic bit ok(int k, logic [2:0] a);
        return int'(a) < dep(k) && !(k == 2 && a == 0);
    endfunction
    function automatic logic [15:0] exp_rd(int k, logic [2:0] a);
        if (!ok(k, a)) return 16'h0;
        if (byp(k) && write && waddr == a) return wdata;
        return mem[k][a];
    endfunction
    function automatic logic exp_busy(int k, logic [2:0] a);
        if (!ok(k, a) || (byp(k) && write && waddr == a)) return 1'b0;
        return pend[k][a];
    endfunction
    function automatic int pcount(int k);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(pend[k][i]);
        return c;
    endfunction
    function automatic void model_reset();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 8; i++) begin
                mem[k][i] = INI;
                pend[k][i] = 0;
            end
    endfunction
    function automatic void chk(string name, int k, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endfunction
    task automatic step(bit rn, bit w, bit [2:0] wa, bit [15:0] wd, bit is, bit [2:0] ia,
                        bit [2:0] a, bit [2:0] b);
        exp_t e;
        resetn = rn; write = w; waddr = wa; wdata = wd; issue = is; iaddr = ia;
        raddr_a = a; raddr_b = b;
        for (int k = 0; k < 3; k++) begin
            e.ra[k] = exp_rd(k, a);
            e.rb[k] = exp_rd(k, b);
            e.ba[k] = exp_busy(k, a);
            e.bb[k] = exp_busy(k, b);
            e.cnt[k] = 4'(pcount(k));
        end
        q.push_back(e);
        @(posedge clock);
        if (!rn) model_reset();
        else
            for (int k = 0; k < 3; k++) begin
                if (w && ok(k, wa)) begin
                    mem[k][wa] = wd;
                    pend[k][wa] = 0;
                end
                if (is && ok(k, ia)) pend[k][ia] = 1;
            end
        #1;
    endtask
    always @(negedge clock) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                chk("rdata_a", k, int'(rda[k]), int'(e.ra[k]));
                chk("rdata_b", k, int'(rdb[k]), int'(e.rb[k]));
                chk("busy_a", k, int'(ba[k]), int'(e.ba[k]));
                chk("busy_b", k, int'(bb[k]), int'(e.bb[k]));
            end
            chk("pend_cnt", 0, int'(cnt0), int'(e.cnt[0]));
            chk("pend_cnt", 1, int'(cnt1), int'(e.cnt[1]));
            chk("pend_cnt", 2, int'(cnt2), int'(e.cnt[2]));
        end
    end
    initial begin
        model_reset();
        @(posedge clock);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 8; i += 2) step(1, 0, 0, 0, 0, 0, 3'(i), 3'(i + 1));
        step(1, 1, 3, 16'h1234, 0, 0, 3, 3);
        step(1, 0, 0, 0, 0, 0, 3, 3);
        step(1, 0, 0, 0, 1, 2, 2, 5);
        step(1, 0, 0, 0, 1, 5, 2, 5);
        step(1, 0, 0, 0, 0, 0, 2, 5);
        step(1, 1, 2, 16'h5A5A, 0, 0, 2, 5);
        step(1, 0, 0, 0, 0, 0, 2, 5);
        step(1, 0, 0, 0, 1, 4, 4, 5);
        step(1, 0, 0, 0, 1, 4, 4, 5);
        step(1, 1, 4, 16'hBEEF, 1, 4, 4, 5);
        step(1, 0, 0, 0, 0, 0, 4, 5);
        step(1, 1, 0, 16'hFFFF, 1, 0, 0, 7);
        step(1, 1, 7, 16'h7777, 1, 7, 0, 7);
        step(1, 0, 0, 0, 0, 0, 0, 7);
        step(1, 0, 0, 0, 1, 1, 1, 3);
        step(1, 0, 0, 0, 1, 3, 1, 3);
        step(1, 0, 0, 0, 1, 6, 1, 6);
        step(0, 1, 1, 16'hDEAD, 1, 2, 1, 6);
        for (int i = 0; i < 8; i += 2) step(1, 0, 0, 0, 0, 0, 3'(i), 3'(i + 1));
        for (int n = 0; n < 500; n++)
            step($urandom_range(49) != 0, 1'($urandom), 3'($urandom), 16'($urandom),
                 1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        repeat (2) @(negedge clock);
        chk("queue_drain", 0, q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
